// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: access sizes, FSM states
// and the acceptance-time alignment check.
package data_mem_responder_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Returns 1 for a misaligned access or the reserved size encoding.
    function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_WORD: return (addr_lo != 2'b00);
            SZ_HALF: return addr_lo[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Little-endian lane selection: extracts and extends a load lane from a memory
// word, and merges right-justified store data into that same word.
module data_mem_responder_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane extraction, extension and read-modify-write merge
    always_comb begin
        byte_lane  = word[{addr_lo, 3'b000} +: 8];
        half_lane  = word[{addr_lo[1], 4'b0000} +: 16];
        load_val   = word;
        store_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_val   = zero_ext ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
                store_word = word;
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_val   = zero_ext ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
                store_word = word;
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_val   = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for CPU load/store requests. One access in flight;
// sub-word stores are performed as read-modify-write of the containing word.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] LAT_LAST = 8'(READ_LAT - 1);

    state_t      state, state_next;
    logic [7:0]  wait_cnt;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_zext;
    logic [1:0]  lat_addr_lo;
    logic [31:0] lat_wdata;
    logic        req_bad;
    logic        rd_done;
    logic [31:0] load_val;
    logic [31:0] store_word;

    assign req_ready = (state == ST_IDLE);
    assign req_bad   = is_bad_req(req_size, req_addr[1:0]);
    assign rd_done   = (wait_cnt == LAT_LAST);

    data_mem_responder_lane_align u_align (
        .word       (mem_rdata),
        .addr_lo    (lat_addr_lo),
        .size       (lat_size),
        .zero_ext   (lat_zext),
        .wdata      (lat_wdata),
        .load_val   (load_val),
        .store_word (store_word)
    );

    // State register
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) state <= ST_IDLE;
        else           state <= state_next;
    end

    // Next-state decode: errors skip memory, word stores skip the read
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_bad)                          state_next = ST_RESP;
                    else if (req_we && req_size == SZ_WORD) state_next = ST_WR;
                    else                                  state_next = ST_RD;
                end
            end
            ST_RD:   if (rd_done) state_next = lat_we ? ST_WR : ST_RESP;
            ST_WR:   state_next = ST_RESP;
            ST_RESP: if (resp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch, read-latency counter, memory port and response registers
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            wait_cnt    <= '0;
            lat_we      <= 1'b0;
            lat_size    <= SZ_WORD;
            lat_zext    <= 1'b0;
            lat_addr_lo <= 2'b00;
            lat_wdata   <= '0;
            mem_addr    <= '0;
            mem_wr      <= 1'b0;
            mem_wdata   <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we      <= req_we;
                        lat_size    <= req_size;
                        lat_zext    <= req_unsigned;
                        lat_addr_lo <= req_addr[1:0];
                        lat_wdata   <= req_wdata;
                        wait_cnt    <= '0;
                        resp_rdata  <= '0;
                        resp_err    <= req_bad;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                        end else begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            if (req_we && req_size == SZ_WORD) begin
                                mem_wdata <= req_wdata;
                                mem_wr    <= 1'b1;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (rd_done) begin
                        wait_cnt <= '0;
                        if (lat_we) begin
                            mem_wdata <= store_word;
                            mem_wr    <= 1'b1;
                        end else begin
                            resp_rdata <= load_val;
                            resp_valid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_WR: begin
                    mem_wr     <= 1'b0;
                    resp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a small synchronous word memory.
module tb_data_mem_responder;

    logic        clk;
    logic        reset_in;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    data_mem_responder #(.READ_LAT(2)) dut (
        .clk          (clk),
        .reset_in     (reset_in),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one-cycle registered read, writes on mem_wr, bench preload port
    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;
    int          wr_total;
    int          overlap;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;

    initial begin
        wr_total = 0;
        overlap  = 0;
        last_wr_addr = '0;
        last_wr_data = '0;
    end

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[7:2]];
        if (mem_wr) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wr_total     <= wr_total + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
        if (mem_wr && resp_valid) overlap <= overlap + 1;
    end

    int n_tests;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_idx  = addr[7:2];
        pre_data = data;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Counts negedges after acceptance until resp_valid is seen; 99 on timeout
    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        if (!resp_valid) lat = 99;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic zext,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_we       = we;
        req_size     = size;
        req_unsigned = zext;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        zext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int lat;
        int wr0;
        logic [31:0] held;

        n_tests      = 0;
        n_fail       = 0;
        pre_we       = 1'b0;
        pre_idx      = '0;
        pre_data     = '0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b1;
        reset_in     = 1'b0;

        //            name        we  size  zx  addr   wdata         init          rdata         err lat wr mem
        vecs[0]  = '{"ld_w",      0, 2'b00, 0, 32'h10, 32'h0,        32'h8899AABB, 32'h8899AABB, 0, 3, 0, 32'h8899AABB};
        vecs[1]  = '{"ld_b_s",    0, 2'b10, 0, 32'h13, 32'h0,        32'h8899AABB, 32'hFFFFFF88, 0, 3, 0, 32'h8899AABB};
        vecs[2]  = '{"ld_b_u",    0, 2'b10, 1, 32'h13, 32'h0,        32'h8899AABB, 32'h00000088, 0, 3, 0, 32'h8899AABB};
        vecs[3]  = '{"ld_h_s",    0, 2'b01, 0, 32'h12, 32'h0,        32'h8899AABB, 32'hFFFF8899, 0, 3, 0, 32'h8899AABB};
        vecs[4]  = '{"ld_h_u0",   0, 2'b01, 1, 32'h10, 32'h0,        32'h8899AABB, 32'h0000AABB, 0, 3, 0, 32'h8899AABB};
        vecs[5]  = '{"ld_b_s0",   0, 2'b10, 0, 32'h10, 32'h0,        32'h8899AABB, 32'hFFFFFFBB, 0, 3, 0, 32'h8899AABB};
        vecs[6]  = '{"ld_b_u1",   0, 2'b10, 1, 32'h11, 32'h0,        32'h8899AABB, 32'h000000AA, 0, 3, 0, 32'h8899AABB};
        vecs[7]  = '{"st_b",      1, 2'b10, 0, 32'h21, 32'h5A,       32'h11223344, 32'h0,        0, 4, 1, 32'h11225A44};
        vecs[8]  = '{"st_h",      1, 2'b01, 0, 32'h22, 32'hBEEF,     32'h11223344, 32'h0,        0, 4, 1, 32'hBEEF3344};
        vecs[9]  = '{"st_b_hi",   1, 2'b10, 0, 32'h24, 32'hFFFFFF77, 32'h11223344, 32'h0,        0, 4, 1, 32'h11223377};
        vecs[10] = '{"st_w",      1, 2'b00, 0, 32'h30, 32'hCAFEF00D, 32'h00000000, 32'h0,        0, 2, 1, 32'hCAFEF00D};
        vecs[11] = '{"err_ld_w",  0, 2'b00, 0, 32'h06, 32'h0,        32'h8899AABB, 32'h0,        1, 1, 0, 32'h8899AABB};
        vecs[12] = '{"err_st_h",  1, 2'b01, 0, 32'h03, 32'hBEEF,     32'h8899AABB, 32'h0,        1, 1, 0, 32'h8899AABB};
        vecs[13] = '{"err_rsv",   0, 2'b11, 0, 32'h40, 32'h0,        32'h8899AABB, 32'h0,        1, 1, 0, 32'h8899AABB};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
        chk("rst_resp_rdata", resp_rdata,          32'h0);
        chk("rst_mem_wr",     {31'h0, mem_wr},     32'h0);
        chk("rst_mem_addr",   mem_addr,            32'h0);
        chk("rst_mem_wdata",  mem_wdata,           32'h0);
        reset_in = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            preload(vecs[i].addr & 32'hFFFF_FFFC, vecs[i].init);
            wr0 = wr_total;
            issue(vecs[i].we, vecs[i].size, vecs[i].zext, vecs[i].addr, vecs[i].wdata);
            wait_resp(lat);
            chk({vecs[i].name, "_lat"},   32'(lat), 32'(vecs[i].exp_lat));
            chk({vecs[i].name, "_rdata"}, resp_rdata, vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"},   {31'h0, resp_err}, {31'h0, vecs[i].exp_err});
            @(negedge clk);
            chk({vecs[i].name, "_wrcnt"}, 32'(wr_total - wr0), 32'(vecs[i].exp_wr));
            chk({vecs[i].name, "_mem"},   mem[vecs[i].addr[7:2]], vecs[i].exp_mem);
            if (vecs[i].exp_wr != 0)
                chk({vecs[i].name, "_wraddr"}, last_wr_addr, vecs[i].addr & 32'hFFFF_FFFC);
        end

        // Backpressure: response held, new request refused until release
        preload(32'h10, 32'h8899AABB);
        resp_ready = 1'b0;
        issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        wait_resp(lat);
        chk("bp_lat", 32'(lat), 32'd3);
        held = resp_rdata;
        wr0  = wr_total;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'h0, resp_valid}, 32'h1);
            chk("bp_rdata", resp_rdata, held);
            chk("bp_ready", {31'h0, req_ready}, 32'h0);
        end
        chk("bp_held_val", held, 32'h8899AABB);
        chk("bp_no_wr", 32'(wr_total - wr0), 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid", {31'h0, resp_valid}, 32'h0);
        chk("bp_rel_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat);
        chk("bp_next_lat", 32'(lat), 32'd2);
        @(negedge clk);
        chk("bp_next_wr", 32'(wr_total - wr0), 32'd1);
        chk("bp_next_data", last_wr_data, 32'h12345678);

        // Reset during the write cycle of a sub-word store
        preload(32'h20, 32'h11223344);
        wr0 = wr_total;
        issue(1'b1, 2'b10, 1'b0, 32'h21, 32'h5A);
        lat = 0;
        while (!mem_wr && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("rst_wr_seen", {31'h0, mem_wr}, 32'h1);
        reset_in = 1'b0;
        #1;
        chk("rst_wr_drop", {31'h0, mem_wr}, 32'h0);
        chk("rst_wr_resp", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        reset_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_after_resp", {31'h0, resp_valid}, 32'h0);
            chk("rst_after_ready", {31'h0, req_ready}, 32'h1);
        end
        chk("rst_no_write", 32'(wr_total - wr0), 32'd0);
        chk("rst_mem_keep", mem[8], 32'h11223344);

        chk("no_wr_resp_overlap", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
